// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner:
// segment patterns, constant glyphs and the load/convert/commit state type.
package seg_pkg;

  // Active-low glyphs, bit order g..a
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {Idle, Conv, Commit} seg_state_e;

  // Nibble to active-low g..a pattern
  function automatic logic [6:0] seg_hex(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b1000000;
      4'h1:    pat = 7'b1111001;
      4'h2:    pat = 7'b0100100;
      4'h3:    pat = 7'b0110000;
      4'h4:    pat = 7'b0011001;
      4'h5:    pat = 7'b0010010;
      4'h6:    pat = 7'b0000010;
      4'h7:    pat = 7'b1111000;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0010000;
      4'hA:    pat = 7'b0001000;
      4'hB:    pat = 7'b0000011;
      4'hC:    pat = 7'b1000110;
      4'hD:    pat = 7'b0100001;
      4'hE:    pat = 7'b0000110;
      default: pat = 7'b0001110;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_bin2bcd.sv
// Sequential double-dabble converter: one binary bit per cycle, VAL_W cycles
// after start. done pulses in the cycle whose clock edge performs the last
// shift, so bcd_out/ovf are final from the following cycle on.
module seg_bin2bcd #(
  parameter int unsigned VAL_W  = 16,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [VAL_W-1:0]      bin_in,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);
  import seg_pkg::*;

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(VAL_W + 1);

  logic [VAL_W-1:0] bin_q;
  logic [BcdW-1:0]  bcd_q;
  logic [BcdW-1:0]  bcd_adj;
  logic [CntW-1:0]  cnt_q;
  logic             run_q;
  logic             ovf_q;
  logic             last;

  // Add-3 correction on every BCD nibble of 5 or more before shifting
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      else                         bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
    end
  end

  assign last = run_q && (cnt_q == CntW'(VAL_W - 1));

  // Load on start, then shift MSB-first; a 1 leaving the top nibble is sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      bin_q <= '0;
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else if (start) begin
      run_q <= 1'b1;
      cnt_q <= '0;
      bin_q <= bin_in;
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else if (run_q) begin
      bcd_q <= {bcd_adj[BcdW-2:0], bin_q[VAL_W-1]};
      bin_q <= bin_q << 1;
      ovf_q <= ovf_q | bcd_adj[BcdW-1];
      cnt_q <= cnt_q + 1'b1;
      if (last) run_q <= 1'b0;
    end
  end

  assign done    = last;
  assign bcd_out = bcd_q;
  assign ovf     = ovf_q;

endmodule

// File: rtl/seg_scan_bcd.sv
// Multiplexed common-anode seven-segment driver for DIGITS digits.
// A binary value is converted to BCD (or taken as hex nibbles), latched into a
// display register and scanned one digit per 2^SCAN_DIV clocks.
// Optional build macro LZ_BLANK_EN: blank leading zero digits (never digit 0).
module seg_scan_bcd #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned VAL_W    = 16,
  parameter int unsigned SCAN_DIV = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [VAL_W-1:0]  disp_num,
  input  logic [DIGITS-1:0] dpdot,
  input  logic              hex_mode,
  output logic              busy,
  output logic [7:0]        segment,
  output logic [DIGITS-1:0] an
);
  import seg_pkg::*;

  localparam int unsigned NibW = 4 * DIGITS;
  localparam int unsigned ExtW = (VAL_W > NibW) ? VAL_W : NibW;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  seg_state_e             state_q;
  logic                   busy_q;
  logic                   hex_sel_q;
  logic [NibW-1:0]        stage_q;
  logic                   stage_ovf_q;
  logic [DIGITS-1:0][3:0] disp_q;
  logic                   disp_ovf_q;
  logic [SCAN_DIV-1:0]    presc_q;
  logic [IdxW-1:0]        idx_q;
  logic [DIGITS-1:0]      an_q;
  logic [7:0]             seg_q;

  logic                   conv_start;
  logic                   conv_done;
  logic [NibW-1:0]        conv_bcd;
  logic                   conv_ovf;
  logic [ExtW-1:0]        num_ext;
  logic [NibW-1:0]        hex_nib;
  logic                   hex_ovf;
  logic [DIGITS-1:0]      blank;
  logic [6:0]             seg_pat;

  // Hex path: zero-extend or truncate to the digit field, flag lost upper bits
  always_comb begin
    num_ext = ExtW'(disp_num);
    hex_nib = num_ext[NibW-1:0];
    hex_ovf = |(num_ext >> NibW);
  end

  assign conv_start = (state_q == Idle) && !hex_mode;

  seg_bin2bcd #(
    .VAL_W  (VAL_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start   (conv_start),
    .bin_in  (disp_num),
    .done    (conv_done),
    .bcd_out (conv_bcd),
    .ovf     (conv_ovf)
  );

  // Sample / convert / commit sequencer owning the display register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= Idle;
      busy_q      <= 1'b0;
      hex_sel_q   <= 1'b0;
      stage_q     <= '0;
      stage_ovf_q <= 1'b0;
      disp_q      <= '0;
      disp_ovf_q  <= 1'b0;
    end else begin
      case (state_q)
        Idle: begin
          if (hex_mode) begin
            stage_q     <= hex_nib;
            stage_ovf_q <= hex_ovf;
            hex_sel_q   <= 1'b1;
            state_q     <= Commit;
          end else begin
            hex_sel_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= Conv;
          end
        end
        Conv: begin
          if (conv_done) begin
            busy_q  <= 1'b0;
            state_q <= Commit;
          end
        end
        Commit: begin
          disp_q     <= hex_sel_q ? stage_q : conv_bcd;
          disp_ovf_q <= hex_sel_q ? stage_ovf_q : conv_ovf;
          state_q    <= Idle;
        end
        default: state_q <= Idle;
      endcase
    end
  end

  // Free-running prescaler; digit index steps when it reaches all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
      if (&presc_q) begin
        if (idx_q == IdxW'(DIGITS - 1)) idx_q <= '0;
        else                            idx_q <= idx_q + 1'b1;
      end
    end
  end

`ifdef LZ_BLANK_EN
  logic lead;

  // Zero digits above the first non-zero one are blanked; digit 0 never is
  always_comb begin
    blank = '0;
    lead  = 1'b1;
    for (int i = int'(DIGITS) - 1; i > 0; i--) begin
      lead     = lead & (disp_q[i] == 4'd0);
      blank[i] = lead;
    end
  end
`else
  assign blank = '0;
`endif

  // Glyph for the digit currently selected by the scan index
  always_comb begin
    if (disp_ovf_q)        seg_pat = SEG_DASH;
    else if (blank[idx_q]) seg_pat = SEG_BLANK;
    else                   seg_pat = seg_hex(disp_q[idx_q]);
  end

  // Registered pin drivers, one cycle behind the scan index
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q  <= ~DIGITS'(1);
      seg_q <= 8'hC0;
    end else begin
      an_q  <= ~(DIGITS'(1) << idx_q);
      seg_q <= {~dpdot[idx_q], seg_pat};
    end
  end

  assign busy    = busy_q;
  assign an      = an_q;
  assign segment = seg_q;

endmodule

// File: doc/seg_scan_bcd.md
Name: seg_scan_bcd

Overview:
Parametrised multiplexed seven-segment driver for N digits. A sequential double-dabble converter turns a binary value into BCD, or the value is passed through as hex nibbles. The result is latched into a display register, and the digits are scanned at a prescaled rate. It sits between game/score logic and the board's common-anode display pins, and replaces the fixed 4-digit divide/modulo driver.

Parameters:
DIGITS, 4, number of display digits / anode lines (1..8)
VAL_W, 16, width of binary input value
SCAN_DIV, 13, prescaler width; scan advances one digit every 2^SCAN_DIV clk cycles

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
disp_num  input  VAL_W  binary value to display
dpdot  input  DIGITS  per-digit decimal point, 1 = lit, bit i -> digit i (digit 0 = rightmost)
hex_mode  input  1  1 = show raw hex nibbles, 0 = show decimal
busy  output  1  converter running; disp_num/hex_mode not being sampled
segment  output  8  active-low segments; [6:0] = g..a, [7] = DP
an  output  DIGITS  active-low digit enables, one-hot-low

Behaviour:
- Reset (sync, active-high): prescaler=0; scan index=0; FSM=IDLE; display register=all digits 0; overflow=0; busy=0; an={DIGITS-1{1},0}; segment=8'hC0 ("0", DP off). Reset mid-conversion aborts the conversion and discards partial results.
- FSM IDLE: each cycle, sample disp_num and hex_mode.
  - hex_mode=1: go to COMMIT. Nibbles are taken directly; the value is zero-extended if VAL_W<4*DIGITS. Overflow=1 if any bit above 4*DIGITS-1 is set.
  - hex_mode=0: load shift register and go to CONV; busy=1.
- CONV: exactly VAL_W cycles of double-dabble. Per cycle, add 3 to each BCD nibble >=5, then shift left 1, MSB of binary first. A bit shifted out of the top BCD nibble sets a sticky overflow flag. Then go to COMMIT.
- COMMIT: one cycle. Write the BCD/nibble result and overflow into the display register; busy=0; go to IDLE.
- Latency from sample to display register: decimal VAL_W+1 cycles, hex 1 cycle. The value is visible on segment at the next scan slot of each digit.
- disp_num/hex_mode changes during CONV are ignored; they are resampled in the next IDLE. No handshake; values are held by the source.
- Scan: the prescaler is a free-running SCAN_DIV-bit counter. On all-ones, the scan index increments and wraps from DIGITS-1 to 0.
- an and segment are registered and update in the cycle after the index changes. an = ~(1<<index).
- segment[6:0] = standard hex pattern of display nibble[index] (0=7'b1000000 ... F=7'b0001110). segment[7] = ~dpdot[index], sampled live.
- Overflow set: every digit shows dash 7'b0111111; DP is still honoured.
- Hex digits A-F are never produced in decimal mode.

Optional Feature:
LZ_BLANK_EN.
- Defined: leading-zero blanking. From the most significant digit down, every zero nibble before the first non-zero nibble shows segment[6:0]=7'h7F. Digit 0 is never blanked. A blanked digit still shows its DP. No blanking while overflow=1.
- Undefined: all digits always show their nibble, including leading zeros.

Decomposition:
- Package seg_pkg:
  - SEG_HEX lookup function (nibble -> 7-bit pattern)
  - constants SEG_DASH=7'b0111111, SEG_BLANK=7'b1111111
  - FSM state typedef {IDLE, CONV, COMMIT}
- Sub-module seg_bin2bcd: the sequential double-dabble engine. Parametrised by VAL_W and DIGITS; ports start/done/bin_in/bcd_out/ovf. The top level keeps the prescaler, scan mux, display register and blanking.

Test Plan:
DIGITS=4, VAL_W=16, SCAN_DIV=2 for all cases.
- Reset, then disp_num=1234, hex_mode=0, dpdot=0 -> busy high for 16 cycles; register committed 17 cycles after sample; scan shows digit0=8'h99, digit1=8'hB0, digit2=8'hA4, digit3=8'hF9 with an=1110,1101,1011,0111 respectively.
- disp_num=10000, hex_mode=0 -> all four digits show 8'hBF (dash); then disp_num=9999 -> all digits 8'h90, overflow clears.
- hex_mode=1, disp_num=16'hBEEF -> committed after 1 cycle; digit0=8'h8E, digit1=8'h86, digit2=8'h86, digit3=8'h83.
- disp_num=1234, dpdot=4'b0100 -> digit2 shows 8'h24, all others have bit7=1; disp_num changed to 5678 mid-CONV -> 1234 committed first, then 5678.
- Assert rst on cycle 8 of CONV -> busy=0 next cycle; an=1110, segment=8'hC0; no commit of the partial value.
- With LZ_BLANK_EN, disp_num=7 -> digit0=8'hF8, digits1-3=8'hFF; disp_num=0 -> digit0=8'hC0, others 8'hFF.
